// File: rtl/lif_pkg.sv
// lif_pkg: shared types and constants for the LIF neuron array.
//   state_t    : sweep controller states.
//   cfg_sel_t  : configuration register select encodings.
//   *_RST      : configuration reset values.
package lif_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CFG_THRESHOLD     = 2'd0,
      CFG_LEAK_SHIFT    = 2'd1,
      CFG_REFRAC_PERIOD = 2'd2,
      CFG_RESERVED      = 2'd3
   } cfg_sel_t;

   localparam int unsigned LEAK_SHIFT_RST    = 32'd1;
   localparam int unsigned REFRAC_PERIOD_RST = 32'd2;

   // Threshold resets to half scale: only the MSB of the membrane word set.
   function automatic int unsigned threshold_rst(input int unsigned width);
      return 32'd1 << (width - 32'd1);
   endfunction

endpackage

// File: rtl/lif_update.sv
// lif_update: combinational single-neuron leaky-integrate-and-fire step.
//   v, current      : stored membrane and input current (unsigned)
//   threshold       : firing threshold
//   leak_shift      : leak = v >> leak_shift (no leak when >= WIDTH)
//   refrac_cnt      : remaining refractory sweeps for this neuron
//   refrac_period   : value loaded into the counter on a spike
//   v_next, spike, refrac_next : updated neuron state
module lif_update #(
   parameter int WIDTH    = 8,
   parameter int REFRAC_W = 4,
   parameter int LS_W     = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0]    v,
   input  logic [WIDTH-1:0]    current,
   input  logic [WIDTH-1:0]    threshold,
   input  logic [LS_W-1:0]     leak_shift,
   input  logic [REFRAC_W-1:0] refrac_cnt,
   input  logic [REFRAC_W-1:0] refrac_period,
   output logic [WIDTH-1:0]    v_next,
   output logic                spike,
   output logic [REFRAC_W-1:0] refrac_next
);

   logic [WIDTH-1:0] leak_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] v_int_s;

   // Leak, saturating integrate, then refractory / fire decision.
   always_comb begin
      leak_s      = {WIDTH{1'b0}};
      sum_s       = {(WIDTH+1){1'b0}};
      v_int_s     = {WIDTH{1'b0}};
      v_next      = v;
      spike       = 1'b0;
      refrac_next = refrac_cnt;

      if (leak_shift >= LS_W'(WIDTH)) begin
         leak_s = {WIDTH{1'b0}};
      end else begin
         leak_s = v >> leak_shift;
      end

      // v - leak never underflows, so only the add needs a carry bit.
      sum_s = {1'b0, v - leak_s} + {1'b0, current};
      if (sum_s[WIDTH]) begin
         v_int_s = {WIDTH{1'b1}};
      end else begin
         v_int_s = sum_s[WIDTH-1:0];
      end

      if (refrac_cnt != {REFRAC_W{1'b0}}) begin
         v_next      = {WIDTH{1'b0}};
         spike       = 1'b0;
         refrac_next = refrac_cnt - REFRAC_W'(1);
      end else if (v_int_s >= threshold) begin
         v_next      = {WIDTH{1'b0}};
         spike       = 1'b1;
         refrac_next = refrac_period;
      end else begin
         v_next      = v_int_s;
         spike       = 1'b0;
         refrac_next = refrac_cnt;
      end
   end

endmodule

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N_NEURONS LIF neurons sharing one update datapath,
// swept one neuron per cycle after each accepted in_valid.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_current : start a sweep with packed per-neuron currents
//   cfg_we/sel/data     : threshold / leak_shift / refrac_period writes (idle only)
//   mon_sel/mon_membrane: combinational peek at one stored membrane
//   spikes/spike_valid  : spike vector of the last sweep, one-cycle update pulse
//   busy                : sweep in progress (RUN or DONE)
module lif_neuron_array
   import lif_pkg::*;
#(
   parameter int N_NEURONS = 4,
   parameter int WIDTH     = 8,
   parameter int REFRAC_W  = 4
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          in_valid,
   input  logic [N_NEURONS*WIDTH-1:0]                    in_current,
   input  logic                                          cfg_we,
   input  logic [1:0]                                    cfg_sel,
   input  logic [WIDTH-1:0]                              cfg_data,
   input  logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] mon_sel,
   output logic [WIDTH-1:0]                              mon_membrane,
   output logic [N_NEURONS-1:0]                          spikes,
   output logic                                          spike_valid,
   output logic                                          busy
);

   localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam int LS_W  = $clog2(WIDTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_NEURONS - 1);
   localparam logic [WIDTH-1:0] THRESH_RST = WIDTH'(threshold_rst(WIDTH));

   state_t                state_r, state_s;
   logic [IDX_W-1:0]      idx_r;
   logic [WIDTH-1:0]      membrane_r [N_NEURONS];
   logic [WIDTH-1:0]      current_r  [N_NEURONS];
   logic [REFRAC_W-1:0]   refrac_r   [N_NEURONS];
   logic [WIDTH-1:0]      threshold_r;
   logic [LS_W-1:0]       leak_shift_r;
   logic [REFRAC_W-1:0]   refrac_period_r;
   logic [N_NEURONS-1:0]  shadow_r, shadow_next_s, spikes_r;
   logic                  spike_valid_r, busy_r;
   logic [WIDTH-1:0]      v_next_s;
   logic                  spike_s;
   logic [REFRAC_W-1:0]   refrac_next_s;

   lif_update #(.WIDTH(WIDTH), .REFRAC_W(REFRAC_W), .LS_W(LS_W)) u_update (
      .v             (membrane_r[idx_r]),
      .current       (current_r[idx_r]),
      .threshold     (threshold_r),
      .leak_shift    (leak_shift_r),
      .refrac_cnt    (refrac_r[idx_r]),
      .refrac_period (refrac_period_r),
      .v_next        (v_next_s),
      .spike         (spike_s),
      .refrac_next   (refrac_next_s)
   );

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Controller next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) state_s = ST_RUN;
            else          state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (idx_r == LAST_IDX) state_s = ST_DONE;
            else                   state_s = ST_RUN;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Shadow spike vector including the neuron being updated this cycle.
   always_comb begin
      shadow_next_s         = shadow_r;
      shadow_next_s[idx_r]  = spike_s;
   end

   // Sweep datapath: latch currents, write back one neuron per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r         <= {IDX_W{1'b0}};
         shadow_r      <= {N_NEURONS{1'b0}};
         spikes_r      <= {N_NEURONS{1'b0}};
         spike_valid_r <= 1'b0;
         busy_r        <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            membrane_r[i] <= {WIDTH{1'b0}};
            current_r[i]  <= {WIDTH{1'b0}};
            refrac_r[i]   <= {REFRAC_W{1'b0}};
         end
      end else begin
         spike_valid_r <= 1'b0;
         busy_r        <= (state_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  idx_r <= {IDX_W{1'b0}};
                  for (int i = 0; i < N_NEURONS; i++) begin
                     current_r[i] <= in_current[i*WIDTH +: WIDTH];
                  end
               end
            end
            ST_RUN: begin
               membrane_r[idx_r] <= v_next_s;
               refrac_r[idx_r]   <= refrac_next_s;
               shadow_r          <= shadow_next_s;
               if (idx_r == LAST_IDX) begin
                  // Publish together with the entry into DONE.
                  spikes_r      <= shadow_next_s;
                  spike_valid_r <= 1'b1;
               end else begin
                  idx_r <= idx_r + IDX_W'(1);
               end
            end
            ST_DONE: idx_r <= {IDX_W{1'b0}};
            default: idx_r <= {IDX_W{1'b0}};
         endcase
      end
   end

   // Configuration registers; writes only land while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         threshold_r     <= THRESH_RST;
         leak_shift_r    <= LS_W'(LEAK_SHIFT_RST);
         refrac_period_r <= REFRAC_W'(REFRAC_PERIOD_RST);
      end else if (cfg_we && (state_r == ST_IDLE)) begin
         case (cfg_sel)
            CFG_THRESHOLD:     threshold_r     <= cfg_data;
            CFG_LEAK_SHIFT:    leak_shift_r    <= LS_W'(cfg_data);
            CFG_REFRAC_PERIOD: refrac_period_r <= REFRAC_W'(cfg_data);
            CFG_RESERVED:      threshold_r     <= threshold_r;
            default:           threshold_r     <= threshold_r;
         endcase
      end
   end

   generate
      if (N_NEURONS == (1 << IDX_W)) begin : g_mon_full
         // Every mon_sel code maps to a neuron.
         always_comb begin
            mon_membrane = membrane_r[mon_sel];
         end
      end else begin : g_mon_partial
         // Codes past the last neuron read as zero.
         always_comb begin
            if (int'(mon_sel) < N_NEURONS) begin
               mon_membrane = membrane_r[mon_sel];
            end else begin
               mon_membrane = {WIDTH{1'b0}};
            end
         end
      end
   endgenerate

   assign spikes      = spikes_r;
   assign spike_valid = spike_valid_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: directed scoreboard bench for lif_neuron_array
// (N_NEURONS=4, WIDTH=8). Stimulus pushes expected spike vectors and issue
// cycles; a monitor pops them whenever spike_valid is seen.
module tb_lif_neuron_array;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_current = 32'd0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_sel = 2'd0;
   logic [7:0]  cfg_data = 8'd0;
   logic [1:0]  mon_sel = 2'd0;
   logic [7:0]  mon_membrane;
   logic [3:0]  spikes;
   logic        spike_valid;
   logic        busy;

   typedef struct {
      logic [3:0] spk;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   lif_neuron_array #(.N_NEURONS(4), .WIDTH(8), .REFRAC_W(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_current   (in_current),
      .cfg_we       (cfg_we),
      .cfg_sel      (cfg_sel),
      .cfg_data     (cfg_data),
      .mon_sel      (mon_sel),
      .mon_membrane (mon_membrane),
      .spikes       (spikes),
      .spike_valid  (spike_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      rst_n    = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic cfg(input logic [1:0] sel, input logic [7:0] data);
      cfg_sel  = sel;
      cfg_data = data;
      cfg_we   = 1'b1;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic check_mon(input string name, input logic [1:0] sel, input logic [7:0] exp);
      mon_sel = sel;
      #1;
      check(name, {24'd0, mon_membrane}, {24'd0, exp});
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy === 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check("busy_drop", {31'd0, busy}, 32'd0);
   endtask

   task automatic sweep(input logic [31:0] cur, input logic [3:0] exp);
      exp_t e;
      e.spk = exp;
      e.cyc = cyc;
      sb.push_back(e);
      in_current = cur;
      in_valid   = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_idle();
   endtask

   // Monitor: every spike_valid pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (spike_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_spike_valid: got spikes %b with no sweep pending", spikes);
            end else begin
               e = sb.pop_front();
               check("spikes", {28'd0, spikes}, {28'd0, e.spk});
               check("latency", cyc, e.cyc + 5);
            end
         end
      end
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_spikes", {28'd0, spikes}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_spike_valid", {31'd0, spike_valid}, 32'd0);
      for (int i = 0; i < 4; i++) check_mon("rst_mon", 2'(i), 8'd0);

      // Integrate then fire; neuron 0 enters refractory afterwards
      sweep({8'd0, 8'd0, 8'd0, 8'd100}, 4'b0000);
      check_mon("int_mon0_s1", 2'd0, 8'd100);
      sweep({8'd0, 8'd0, 8'd0, 8'd100}, 4'b0001);
      check_mon("int_mon0_s2", 2'd0, 8'd0);

      // Refractory: two held sweeps, then fire again
      sweep({8'd0, 8'd0, 8'd0, 8'd255}, 4'b0000);
      check_mon("ref_mon0_a", 2'd0, 8'd0);
      sweep({8'd0, 8'd0, 8'd0, 8'd255}, 4'b0000);
      check_mon("ref_mon0_b", 2'd0, 8'd0);
      sweep({8'd0, 8'd0, 8'd0, 8'd255}, 4'b0001);
      check_mon("ref_mon0_c", 2'd0, 8'd0);

      // Saturation with no leak
      do_reset();
      cfg(2'd1, 8'd8);
      cfg(2'd0, 8'd255);
      sweep({8'd0, 8'd0, 8'd30, 8'd200}, 4'b0000);
      check_mon("sat_mon0_s1", 2'd0, 8'd200);
      check_mon("sat_mon1_s1", 2'd1, 8'd30);
      sweep({8'd0, 8'd0, 8'd30, 8'd200}, 4'b0001);
      check_mon("sat_mon0_s2", 2'd0, 8'd0);
      check_mon("sat_mon1_s2", 2'd1, 8'd60);

      // Threshold zero: all fire, then all refractory
      do_reset();
      cfg(2'd0, 8'd0);
      sweep(32'd0, 4'b1111);
      sweep(32'd0, 4'b0000);

      // Busy rules: in_valid and cfg_we during RUN are dropped
      do_reset();
      begin
         exp_t e;
         e.spk = 4'b0000;
         e.cyc = cyc;
         sb.push_back(e);
      end
      in_current = {8'd0, 8'd0, 8'd0, 8'd100};
      in_valid   = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      in_current = {8'd200, 8'd200, 8'd200, 8'd200};
      in_valid   = 1'b1;
      cfg_sel    = 2'd0;
      cfg_data   = 8'd10;
      cfg_we     = 1'b1;
      tick();
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      wait_idle();
      repeat (8) tick();
      check_mon("busy_mon0", 2'd0, 8'd100);
      check_mon("busy_mon1", 2'd1, 8'd0);
      // 100-50+0=50: fires only if the dropped threshold write landed
      sweep(32'd0, 4'b0000);
      check_mon("busy_thr_mon0", 2'd0, 8'd50);

      // Mid-sweep reset: abandon with no pulse
      do_reset();
      in_current = {8'd100, 8'd100, 8'd100, 8'd100};
      in_valid   = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check_mon("mid_pre_mon0", 2'd0, 8'd100);
      rst_n = 1'b0;
      #1;
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_spike_valid", {31'd0, spike_valid}, 32'd0);
      for (int i = 0; i < 4; i++) check_mon("mid_mon", 2'(i), 8'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("mid_spikes", {28'd0, spikes}, 32'd0);

      check("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
